pwm_multi: RTL
==============

Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator, the successor to the single-channel motor PWM in mcu_pwm. It drives NCH independent outputs from one shared prescaler, with per-channel period, duty and polarity. Per-channel settings are double-buffered and take effect only at a period boundary, so outputs never glitch. It sits behind the MCU register bank; one write port addresses one channel at a time.

Parameters:
NCH, 8, number of PWM channels (1..16)
CW, 24, counter/period/duty width in bits
PSW, 8, prescaler divider width in bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-low
prescale  input  PSW  tick every prescale+1 clk cycles; sampled continuously
wr_en  input  1  one-cycle write strobe
wr_ch  input  clog2(NCH)  target channel of write
wr_period  input  CW  new period in ticks; 0 = channel idle
wr_duty  input  CW  new high time in ticks
wr_inv  input  1  new output polarity (1 = inverted)
ch_enable  input  NCH  per-channel run enable, level
pwm_out  output  NCH  PWM outputs, registered
period_done  output  NCH  one-clk pulse when a channel wraps

Behaviour:
- Reset (reset==0 at a clk edge): prescaler, all counters, all pending and active registers, and all pending flags clear. pwm_out=0 and period_done=0 the following cycle.
- Prescaler: a shared counter runs 0..prescale. tick is asserted on the cycle it equals prescale, and the counter returns to 0. With prescale=0, tick is asserted every cycle. If prescale is lowered below the current count, the counter wraps at the CW-agnostic max and then continues; there is no mid-count reload.
- Write: when wr_en=1 and wr_ch<NCH, the channel's pending {period, duty_clamped, inv} is updated and its pend flag set. duty_clamped = min(wr_duty, wr_period). wr_ch>=NCH is ignored.
- Load into active:
  - at the tick where counter==period_act-1 (the period end), or
  - on any cycle where period_act==0 (idle channel loads immediately, one cycle after the write).
  - The load clears pend. A write and a load in the same cycle: the load takes the old pending value, the new write is latched, and pend stays 1.
- Counter, per channel, advances on tick only:
  - ch_enable=0 or period_act==0: counter held at 0.
  - else if counter==period_act-1: counter=0, and period_done pulses for one clk.
  - else counter+1.
- Output: raw = (counter < duty_act). pwm_out = raw XOR inv_act, registered, so it lags the counter by 1 clk.
  - duty_act==0 gives constant inactive level.
  - duty_act==period_act gives constant active level.
  - Disabled or idle channel drives inv_act (the inactive level).
- ch_enable deasserted mid-period: the counter resets to 0. Re-enabling starts a fresh period at counter 0, with the output active if duty>0.
- Channels are fully independent. The only shared resource is the prescaler tick.
- Arithmetic is unsigned CW-bit. period_act-1 is evaluated only when period_act!=0.

Decomposition:
- Shared package pwm_pkg: default CW/PSW constants and a channel config struct {period, duty, inv}.
- Sub-module pwm_channel: pending/active registers, counter, compare and output register, taking tick and the decoded write strobe. It is instantiated NCH times in a generate loop.
- The top level holds the prescaler and the write decode.

Test Plan:
- Basic waveform: prescale=0, ch0 period=10 duty=3 inv=0, enable → pwm_out[0] high 3 clk / low 7 clk, repeating. period_done[0] pulses every 10 clk.
- Clamp and extremes: ch1 duty=20 period=10 → constant 1. Duty=0 → constant 0. inv=1 with duty=0 → constant 1.
- Glitch-free update: ch0 running period=10 duty=3; write duty=7 at count 5 → the current period still ends high 3. The next period is high 7, aligned to the period_done pulse.
- Prescaler: prescale=3, period=4, duty=2 → high 8 clk / low 8 clk. Channel ch2 with period=0 → output stays at inactive level and period_done never fires.
- Collision and disable: write ch0 in the same clk as its period-end load → old pending applied, new value applied the next period. Drop ch_enable mid-period → output goes inactive 1 clk later; re-enable restarts at count 0.
- Reset mid-operation: pull reset low while 4 channels toggle → all pwm_out=0 next clk. After release with no writes, outputs stay 0 indefinitely.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM.
// Provides default widths, the per-channel configuration record and the
// helper that builds a write payload with the duty clamped to the period.
package pwm_pkg;

    localparam int unsigned CW_DEF  = 24;
    localparam int unsigned PSW_DEF = 8;
    // Config fields are held at a fixed maximum width; the upper bits stay zero
    // when CW is smaller, so the record type is independent of CW.
    localparam int unsigned CW_MAX  = 32;

    typedef struct packed {
        logic [CW_MAX-1:0] period;
        logic [CW_MAX-1:0] duty;
        logic              inv;
    } pwm_cfg_t;

    // Build a config with duty limited to period (duty > period means "always active").
    function automatic pwm_cfg_t make_cfg(input logic [CW_MAX-1:0] period,
                                          input logic [CW_MAX-1:0] duty,
                                          input logic              inv);
        pwm_cfg_t cfg;
        cfg.period = period;
        cfg.duty   = (duty > period) ? period : duty;
        cfg.inv    = inv;
        return cfg;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered config, period counter, compare, output register.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   tick_i       shared prescaler tick (counter advances only on tick)
//   en_i         run enable, level
//   wr_stb_i     write strobe already decoded for this channel
//   wr_cfg_i     clamped write payload
//   pwm_o        registered PWM output
//   done_o       one-clk pulse when the counter wraps
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tick_i,
    input  logic     en_i,
    input  logic     wr_stb_i,
    input  pwm_cfg_t wr_cfg_i,
    output logic     pwm_o,
    output logic     done_o
);

    pwm_cfg_t          pend_q, pend_d;
    pwm_cfg_t          act_q, act_d;
    logic              pend_vld_q, pend_vld_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pwm_q, pwm_d;
    logic              done_q, done_d;
    logic [CW_MAX-1:0] cnt_ext;
    logic              idle, at_end, wrap, load;

    // Period-end detection, load decision and next-state.
    always_comb begin
        cnt_ext    = CW_MAX'(cnt_q);
        idle       = (act_q.period == '0);
        // period-1 is only meaningful for a non-idle channel
        at_end     = !idle && (cnt_ext == (act_q.period - CW_MAX'(1)));
        wrap       = tick_i && en_i && at_end;
        // idle channels pick up a pending config on the very next cycle
        load       = pend_vld_q && (idle || wrap);

        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;
        cnt_d      = cnt_q;

        // load consumes the old pending value; a simultaneous write re-arms pend
        if (load) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (wr_stb_i) begin
            pend_d     = wr_cfg_i;
            pend_vld_d = 1'b1;
        end

        if (!en_i || idle) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
        end

        done_d = wrap;
        pwm_d  = (en_i && !idle && (cnt_ext < act_q.duty)) ^ act_q.inv;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= '0;
            act_q      <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            pwm_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            act_q      <= act_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            done_q     <= done_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign done_o = done_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared prescaler and one write port.
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-low
//   prescale     tick every prescale+1 clk cycles
//   wr_en        write strobe; wr_ch selects the channel (out-of-range ignored)
//   wr_period    new period in ticks (0 = idle)
//   wr_duty      new high time in ticks (clamped to period)
//   wr_inv       new polarity (1 = inverted)
//   ch_enable    per-channel run enable
//   pwm_out      registered PWM outputs
//   period_done  one-clk pulse per channel wrap
module pwm_multi
    import pwm_pkg::*;
#(
    parameter  int unsigned NCH = 8,
    parameter  int unsigned CW  = CW_DEF,
    parameter  int unsigned PSW = PSW_DEF,
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [PSW-1:0] prescale,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_period,
    input  logic [CW-1:0]  wr_duty,
    input  logic           wr_inv,
    input  logic [NCH-1:0] ch_enable,
    output logic [NCH-1:0] pwm_out,
    output logic [NCH-1:0] period_done
);

    if (NCH < 1 || NCH > 16 || CW < 1 || CW > CW_MAX) begin : g_bad_param
        $error("pwm_multi: parameter out of range");
    end

    logic [PSW-1:0] psc_q, psc_d;
    logic           tick;
    logic           wr_ok;
    pwm_cfg_t       wr_cfg;

    // Free-running prescaler; a lowered prescale is not reloaded, the count wraps naturally.
    always_comb begin
        tick  = (psc_q == prescale);
        psc_d = tick ? '0 : psc_q + PSW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) psc_q <= '0;
        else        psc_q <= psc_d;
    end

    always_comb begin
        wr_ok  = wr_en && (32'(wr_ch) < NCH);
        wr_cfg = make_cfg(CW_MAX'(wr_period), CW_MAX'(wr_duty), wr_inv);
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_channel #(.CW(CW)) u_ch (
            .clk      (clk),
            .rst_n    (reset),
            .tick_i   (tick),
            .en_i     (ch_enable[g]),
            .wr_stb_i (wr_ok && (wr_ch == CHW'(g))),
            .wr_cfg_i (wr_cfg),
            .pwm_o    (pwm_out[g]),
            .done_o   (period_done[g])
        );
    end

endmodule
